time_bus_master: RTL and testbench

// CPU-side initiator for the seconds-clock register interface: drives wr/waddr/wdata
// and rd/raddr, consumes rdata. Periodically polls RUN_TIME, converts seconds-of-day to

---
 rtl/time_bus_master.sv | 177 +++++++++++++++++
 tb/tb_time_bus_master.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_bus_master.sv
// Bus initiator for the seconds-of-day time block: polls RUN_TIME, converts the
// value to hour/min/sec by repeated subtraction, and issues CLR / INIT_TIME writes.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | nothing in flight; arbitrates clr > set > poll
// WR_CLR  | wr strobe to CLR with data 1
// GAP     | forced idle bus cycle so the responder sees CLR drop
// WR_INIT | wr strobe to INIT_TIME with latched set value
// RD_REQ  | rd strobe to RUN_TIME
// RD_WAIT | capture rdata, range check
// CONV_H  | subtract 3600 per cycle, count hours
// CONV_M  | subtract 60 per cycle, count minutes
// DONE    | hour/min/sec just loaded, time_vld high
module time_bus_master #(
    parameter int ADDRWIDTH = 4,
    parameter int POLL_CNT  = 5000000,
    parameter int CNT_WIDTH = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 key_clr,
    input  logic                 key_set,
    input  logic [16:0]          set_time,
    output logic                 wr,
    output logic [ADDRWIDTH-1:0] waddr,
    output logic [31:0]          wdata,
    output logic                 rd,
    output logic [ADDRWIDTH-1:0] raddr,
    input  logic [31:0]          rdata,
    output logic [4:0]           hour,
    output logic [5:0]           min,
    output logic [5:0]           sec,
    output logic                 time_vld,
    output logic                 rd_err,
    output logic                 busy
);

    localparam logic [ADDRWIDTH-1:0] ADDR_RUN  = ADDRWIDTH'(4'h4);
    localparam logic [ADDRWIDTH-1:0] ADDR_CLR  = ADDRWIDTH'(4'h8);
    localparam logic [ADDRWIDTH-1:0] ADDR_INIT = ADDRWIDTH'(4'hc);
    localparam logic [CNT_WIDTH-1:0] POLL_LAST = CNT_WIDTH'(POLL_CNT - 1);
    localparam logic [31:0]          SEC_PER_DAY = 32'd86400;

    typedef enum logic [3:0] {
        IDLE, WR_CLR, GAP, WR_INIT, RD_REQ, RD_WAIT, CONV_H, CONV_M, DONE
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] poll_cnt;
    logic                 poll_tc;
    logic                 clr_pend;
    logic                 set_pend;
    logic                 poll_pend;
    logic [16:0]          set_val;
    logic [16:0]          work;
    logic [4:0]           h_cnt;
    logic [5:0]           m_cnt;

    assign poll_tc = (poll_cnt == POLL_LAST);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_cnt <= '0;
        end else if (poll_tc) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr        <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            rd        <= 1'b0;
            raddr     <= '0;
            hour      <= '0;
            min       <= '0;
            sec       <= '0;
            time_vld  <= 1'b0;
            rd_err    <= 1'b0;
            clr_pend  <= 1'b0;
            set_pend  <= 1'b0;
            poll_pend <= 1'b0;
            set_val   <= '0;
            work      <= '0;
            h_cnt     <= '0;
            m_cnt     <= '0;
        end else begin
            wr       <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            rd       <= 1'b0;
            raddr    <= '0;
            time_vld <= 1'b0;
            rd_err   <= 1'b0;

            case (state)
                IDLE: begin
                    if (clr_pend) begin
                        state    <= WR_CLR;
                        wr       <= 1'b1;
                        waddr    <= ADDR_CLR;
                        wdata    <= 32'd1;
                        clr_pend <= 1'b0;
                    end else if (set_pend) begin
                        state    <= WR_INIT;
                        wr       <= 1'b1;
                        waddr    <= ADDR_INIT;
                        wdata    <= {15'b0, set_val};
                        set_pend <= 1'b0;
                    end else if (poll_pend) begin
                        state <= RD_REQ;
                        rd    <= 1'b1;
                        raddr <= ADDR_RUN;
                    end
                end
                WR_CLR:  state <= GAP;
                GAP:     state <= IDLE;
                WR_INIT: state <= IDLE;
                RD_REQ:  state <= RD_WAIT;
                RD_WAIT: begin
                    poll_pend <= 1'b0;
                    h_cnt     <= '0;
                    m_cnt     <= '0;
                    work      <= rdata[16:0];
                    if (rdata >= SEC_PER_DAY) begin
                        rd_err <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        state <= CONV_H;
                    end
                end
                CONV_H: begin
                    if (work >= 17'd3600) begin
                        work  <= work - 17'd3600;
                        h_cnt <= h_cnt + 5'd1;
                    end else begin
                        state <= CONV_M;
                    end
                end
                CONV_M: begin
                    if (work >= 17'd60) begin
                        work  <= work - 17'd60;
                        m_cnt <= m_cnt + 6'd1;
                    end else begin
                        // all three fields land in the same cycle so the display never tears
                        hour     <= h_cnt;
                        min      <= m_cnt;
                        sec      <= work[5:0];
                        time_vld <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            // captures come after the FSM so a key arriving as its write issues is not lost
            if (key_clr) begin
                clr_pend <= 1'b1;
            end
            if (key_set) begin
                set_pend <= 1'b1;
                set_val  <= set_time;
            end
            if (poll_tc) begin
                poll_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_time_bus_master.sv
// Self-checking bench for time_bus_master: table-driven polls, key sequences,
// reset abort, and randomized polls against an arithmetic h/m/s reference.
module tb_time_bus_master;

    localparam int ADDRWIDTH = 4;
    localparam int POLL_CNT  = 200;
    localparam int CNT_WIDTH = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 key_clr = 1'b0;
    logic                 key_set = 1'b0;
    logic [16:0]          set_time = '0;
    logic                 wr;
    logic [ADDRWIDTH-1:0] waddr;
    logic [31:0]          wdata;
    logic                 rd;
    logic [ADDRWIDTH-1:0] raddr;
    logic [31:0]          rdata = '0;
    logic [4:0]           hour;
    logic [5:0]           min;
    logic [5:0]           sec;
    logic                 time_vld;
    logic                 rd_err;
    logic                 busy;

    time_bus_master #(
        .ADDRWIDTH(ADDRWIDTH),
        .POLL_CNT (POLL_CNT),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_clr (key_clr),
        .key_set (key_set),
        .set_time(set_time),
        .wr      (wr),
        .waddr   (waddr),
        .wdata   (wdata),
        .rd      (rd),
        .raddr   (raddr),
        .rdata   (rdata),
        .hour    (hour),
        .min     (min),
        .sec     (sec),
        .time_vld(time_vld),
        .rd_err  (rd_err),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int idle_viol = 0;
    int prev_h = 0, prev_m = 0, prev_s = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // bus protocol invariants sampled every cycle away from the clock edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr || rd) begin
                n_cmp++;
                if (wr && rd) begin
                    n_bad++;
                    $display("FAIL strobe_excl: got wr=%0b rd=%0b expected one-hot", wr, rd);
                end
            end
            if (!wr && (waddr != '0 || wdata != '0)) idle_viol++;
            if (!rd && raddr != '0) idle_viol++;
            if (wr && !(waddr == 4'h8 || waddr == 4'hc)) idle_viol++;
            if (rd && raddr != 4'h4) idle_viol++;
        end
    end

    function automatic void ref_conv(input int v, output bit err, output int h,
                                     output int m, output int s);
        err = (v >= 86400);
        h = v / 3600;
        m = (v % 3600) / 60;
        s = v % 60;
    endfunction

    task automatic wait_rd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < POLL_CNT + 120; i++) begin
            @(negedge clk);
            if (rd) begin
                ok = 1'b1;
                break;
            end
        end
        check("rd_arrives", {31'b0, ok}, 32'd1);
    endtask

    task automatic do_poll(input logic [31:0] v, input bit exp_err,
                           input int eh, input int em, input int es);
        bit ok;
        int lat;
        rdata = v;
        wait_rd(ok);
        if (!ok) return;
        check("poll_raddr", 32'(raddr), 32'd4);
        @(negedge clk);
        check("rd_one_cycle", {31'b0, rd}, 32'd0);
        lat = 1;
        for (int i = 1; i <= 100; i++) begin
            if (time_vld || rd_err) break;
            @(negedge clk);
            lat = i + 1;
        end
        if (exp_err) begin
            check("rd_err_seen", {31'b0, rd_err}, 32'd1);
            check("err_no_vld", {31'b0, time_vld}, 32'd0);
        end else begin
            check("vld_seen", {31'b0, time_vld}, 32'd1);
            check("latency_le_87", {31'b0, (lat <= 87)}, 32'd1);
        end
        check("hour", 32'(hour), 32'(eh));
        check("min", 32'(min), 32'(em));
        check("sec", 32'(sec), 32'(es));
        prev_h = eh;
        prev_m = em;
        prev_s = es;
    endtask

    typedef struct {
        logic [31:0] v;
        bit          err;
        int          h;
        int          m;
        int          s;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int wr_addr_q[$];
        int wr_data_q[$];
        int wr_cyc_q[$];
        int vld_cyc;
        int n_rd;
        int n_act;

        // expected h/m/s on error rows are the values held from the previous row
        vecs[0] = '{32'd3661,  1'b0, 1,  1,  1};
        vecs[1] = '{32'd90000, 1'b1, 1,  1,  1};
        vecs[2] = '{32'd86399, 1'b0, 23, 59, 59};
        vecs[3] = '{32'd0,     1'b0, 0,  0,  0};
        vecs[4] = '{32'd3600,  1'b0, 1,  0,  0};
        vecs[5] = '{32'd59,    1'b0, 0,  0,  59};
        vecs[6] = '{32'd86400, 1'b1, 0,  0,  59};
        vecs[7] = '{32'd60,    1'b0, 0,  1,  0};

        #1;
        check("rst_wr", {31'b0, wr}, 32'd0);
        check("rst_rd", {31'b0, rd}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_hms", {15'b0, hour, min, sec}, 32'd0);
        check("rst_pulses", {30'b0, time_vld, rd_err}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            do_poll(vecs[i].v, vecs[i].err, vecs[i].h, vecs[i].m, vecs[i].s);
        end

        // clear and set requested together: CLR first, idle gap, then INIT
        @(negedge clk);
        key_clr = 1'b1;
        key_set = 1'b1;
        set_time = 17'd45000;
        @(negedge clk);
        key_clr = 1'b0;
        key_set = 1'b0;
        set_time = '0;
        n_rd = 0;
        for (int i = 0; i < 20; i++) begin
            if (wr) begin
                wr_addr_q.push_back(int'(waddr));
                wr_data_q.push_back(int'(wdata));
                wr_cyc_q.push_back(i);
            end
            if (rd) n_rd++;
            @(negedge clk);
        end
        check("clrset_nwr", 32'(wr_addr_q.size()), 32'd2);
        check("clrset_nrd", 32'(n_rd), 32'd0);
        if (wr_addr_q.size() == 2) begin
            check("clr_addr", 32'(wr_addr_q[0]), 32'h8);
            check("clr_data", 32'(wr_data_q[0]), 32'd1);
            check("init_addr", 32'(wr_addr_q[1]), 32'hc);
            check("init_data", 32'(wr_data_q[1]), 32'd45000);
            check("clr_gap", {31'b0, (wr_cyc_q[1] - wr_cyc_q[0] >= 2)}, 32'd1);
        end
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();

        // key_set twice during CONV_M: conversion finishes, then INIT with the later value
        rdata = 32'd86399;
        wait_rd(ok);
        if (ok) begin
            repeat (40) @(negedge clk);
            check("busy_in_conv", {31'b0, busy}, 32'd1);
            key_set = 1'b1;
            set_time = 17'd12345;
            @(negedge clk);
            set_time = 17'd777;
            @(negedge clk);
            key_set = 1'b0;
            set_time = '0;
            vld_cyc = -1;
            for (int i = 0; i < 80; i++) begin
                if (time_vld && vld_cyc < 0) begin
                    vld_cyc = i;
                    check("conv_hour", 32'(hour), 32'd23);
                    check("conv_min", 32'(min), 32'd59);
                    check("conv_sec", 32'(sec), 32'd59);
                end
                if (wr) begin
                    wr_addr_q.push_back(int'(waddr));
                    wr_data_q.push_back(int'(wdata));
                    wr_cyc_q.push_back(i);
                end
                @(negedge clk);
            end
            check("conv_vld_seen", {31'b0, (vld_cyc >= 0)}, 32'd1);
            check("conv_nwr", 32'(wr_addr_q.size()), 32'd1);
            if (wr_addr_q.size() == 1) begin
                check("late_init_addr", 32'(wr_addr_q[0]), 32'hc);
                check("late_init_data", 32'(wr_data_q[0]), 32'd777);
                check("init_after_vld", {31'b0, (wr_cyc_q[0] > vld_cyc)}, 32'd1);
            end
            prev_h = 23;
            prev_m = 59;
            prev_s = 59;
        end

        // reset while CONV_H is running
        rdata = 32'd86399;
        wait_rd(ok);
        if (ok) begin
            repeat (10) @(negedge clk);
            check("busy_in_convh", {31'b0, busy}, 32'd1);
            rst_n = 1'b0;
            #1;
            check("arst_wr_rd", {30'b0, wr, rd}, 32'd0);
            check("arst_hms", {15'b0, hour, min, sec}, 32'd0);
            check("arst_busy", {31'b0, busy}, 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            check("post_rst_busy", {31'b0, busy}, 32'd0);
            check("post_rst_wr_rd", {30'b0, wr, rd}, 32'd0);
            n_act = 0;
            for (int i = 0; i < 100; i++) begin
                if (wr || rd || time_vld || rd_err) n_act++;
                @(negedge clk);
            end
            check("post_rst_quiet", 32'(n_act), 32'd0);
            check("post_rst_hms", {15'b0, hour, min, sec}, 32'd0);
            prev_h = 0;
            prev_m = 0;
            prev_s = 0;
        end

        for (int k = 0; k < 15; k++) begin
            int v, h, m, s;
            bit err;
            v = int'($urandom_range(0, 99999));
            ref_conv(v, err, h, m, s);
            if (err) begin
                h = prev_h;
                m = prev_m;
                s = prev_s;
            end
            do_poll(32'(v), err, h, m, s);
        end

        check("idle_bus_zero", 32'(idle_viol), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
